// File: rtl/mem_block_responder_pkg.sv
// Shared memory-interface constants: widths, burst length and responder state encodings.
// Also holds the multiplier-free block-to-word address helper.
package mem_block_responder_pkg;
  localparam int ADDR_WIDTH           = 8;
  localparam int MEM_DATA_WIDTH       = 32;
  localparam int NUM_MEM_TRANSACTIONS = 10;
  localparam int WORD_ADDR_WIDTH      = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // blk*10 as blk*8 + blk*2, truncated to the word-address width.
  function automatic logic [WORD_ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] blk);
    logic [WORD_ADDR_WIDTH-1:0] a;
    a = {{(WORD_ADDR_WIDTH-ADDR_WIDTH){1'b0}}, blk};
    return (a << 3) + (a << 1);
  endfunction
endpackage

// File: rtl/mem_block_responder_mem_word_array.sv
// Backing word store: one write port, one synchronous read port with 1-cycle latency.
// The read register only loads when rd_en_i is high, so it holds its word otherwise.
module mem_word_array
  import mem_block_responder_pkg::*;
#(
  parameter int WORD_DEPTH = 2560
) (
  input  logic                       clk,
  input  logic                       rd_en_i,
  input  logic [WORD_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [MEM_DATA_WIDTH-1:0]  rd_data_o,
  input  logic                       wr_en_i,
  input  logic [WORD_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0]  wr_data_i
);
  logic [MEM_DATA_WIDTH-1:0] mem_q [WORD_DEPTH];
  logic [MEM_DATA_WIDTH-1:0] rd_data_q;

  // Same-address read/write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en_i && (int'({20'd0, wr_addr_i}) < WORD_DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/mem_block_responder.sv
// Block responder: accepts a block address, waits LATENCY cycles (and for ready),
// then streams the block's 10 words back-to-back from the backing array.
module mem_block_responder
  import mem_block_responder_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int WORD_DEPTH = 2560
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       i_halt,
  input  logic [ADDR_WIDTH-1:0]      i_mem_req_addr,
  input  logic                       i_mem_req_valid,
  input  logic                       i_mem_ready,
  output logic [MEM_DATA_WIDTH-1:0]  o_mem_data,
  output logic                       o_mem_data_valid,
  output logic                       o_busy,
  input  logic                       i_wr_en,
  input  logic [WORD_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [MEM_DATA_WIDTH-1:0]  i_wr_data
);
  localparam logic [3:0] LAT_LOAD  = 4'(LATENCY - 1);
  localparam logic [3:0] LAST_WORD = 4'(NUM_MEM_TRANSACTIONS - 1);

  logic [1:0]                 state_q, state_d;
  logic [3:0]                 lat_cnt_q, lat_cnt_d;
  logic [3:0]                 word_idx_q, word_idx_d;
  logic [ADDR_WIDTH-1:0]      blk_addr_q, blk_addr_d;
  logic                       valid_q, valid_d;
  logic                       rd_en;
  logic [WORD_ADDR_WIDTH-1:0] base_addr, rd_addr;
  logic [MEM_DATA_WIDTH-1:0]  rd_data;

  assign base_addr = block_base(blk_addr_q);

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    word_idx_d = word_idx_q;
    blk_addr_d = blk_addr_q;
    valid_d    = valid_q;
    rd_en      = 1'b0;
    rd_addr    = base_addr + {8'd0, word_idx_q} + 12'd1;
    if (!i_halt) begin
      case (state_q)
        ST_IDLE: begin
          valid_d = 1'b0;
          if (i_mem_req_valid) begin
            state_d    = ST_WAIT;
            blk_addr_d = i_mem_req_addr;
            lat_cnt_d  = LAT_LOAD;
            word_idx_d = 4'd0;
          end
        end
        ST_WAIT: begin
          if (lat_cnt_q != 4'd0) begin
            lat_cnt_d = lat_cnt_q - 4'd1;
          end else if (i_mem_ready) begin
            // Word 0 is fetched now so it is presented on the SEND entry edge.
            state_d    = ST_SEND;
            valid_d    = 1'b1;
            word_idx_d = 4'd0;
            rd_en      = 1'b1;
            rd_addr    = base_addr;
          end
        end
        ST_SEND: begin
          if (word_idx_q == LAST_WORD) begin
            state_d    = ST_IDLE;
            valid_d    = 1'b0;
            word_idx_d = 4'd0;
          end else begin
            word_idx_d = word_idx_q + 4'd1;
            rd_en      = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= 4'd0;
      word_idx_q <= 4'd0;
      blk_addr_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      word_idx_q <= word_idx_d;
      blk_addr_q <= blk_addr_d;
      valid_q    <= valid_d;
    end
  end

  mem_word_array #(
    .WORD_DEPTH(WORD_DEPTH)
  ) u_array (
    .clk      (clk),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .wr_en_i  (i_wr_en),
    .wr_addr_i(i_wr_addr),
    .wr_data_i(i_wr_data)
  );

  assign o_mem_data       = valid_q ? rd_data : '0;
  assign o_mem_data_valid = valid_q;
  assign o_busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_block_responder.sv
// Bench for mem_block_responder: directed block scenarios plus randomized traffic,
// checked every cycle against a tick-counting transaction model of the responder.
module tb_mem_block_responder;
  localparam int LATENCY    = 4;
  localparam int WORD_DEPTH = 2560;

  logic        clk;
  logic        arst_n;
  logic        i_halt;
  logic [7:0]  i_mem_req_addr;
  logic        i_mem_req_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_data;
  logic        o_mem_data_valid;
  logic        o_busy;
  logic        i_wr_en;
  logic [11:0] i_wr_addr;
  logic [31:0] i_wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  mem_block_responder #(
    .LATENCY(LATENCY),
    .WORD_DEPTH(WORD_DEPTH)
  ) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .i_halt          (i_halt),
    .i_mem_req_addr  (i_mem_req_addr),
    .i_mem_req_valid (i_mem_req_valid),
    .i_mem_ready     (i_mem_ready),
    .o_mem_data      (o_mem_data),
    .o_mem_data_valid(o_mem_data_valid),
    .o_busy          (o_busy),
    .i_wr_en         (i_wr_en),
    .i_wr_addr       (i_wr_addr),
    .i_wr_data       (i_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time measured in non-halted ticks since the accepting edge.
  logic [31:0] ref_mem [WORD_DEPTH];
  bit          m_busy, m_send, m_valid;
  int          m_tick, m_t0, m_word, m_base;
  logic [31:0] m_data = 32'd0;

  initial forever begin
    @(posedge clk);
    if (!arst_n) begin
      m_busy = 0; m_send = 0; m_valid = 0; m_data = 32'd0; m_tick = 0;
    end else if (!i_halt) begin
      m_tick++;
      if (!m_busy) begin
        m_valid = 0; m_data = 32'd0;
        if (i_mem_req_valid) begin
          m_busy = 1; m_t0 = m_tick; m_base = i_mem_req_addr * 10;
        end
      end else if (!m_send) begin
        if ((m_tick - m_t0) >= LATENCY && i_mem_ready) begin
          m_send = 1; m_word = 0; m_valid = 1; m_data = ref_mem[m_base];
        end
      end else if (m_word == 9) begin
        $display("stream done: words %0d..%0d", m_base, m_base + 9);
        m_busy = 0; m_send = 0; m_valid = 0; m_data = 32'd0;
      end else begin
        m_word++;
        m_data = ref_mem[m_base + m_word];
      end
    end
    if (i_wr_en && int'(i_wr_addr) < WORD_DEPTH) ref_mem[i_wr_addr] = i_wr_data;
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("valid", {31'd0, o_mem_data_valid}, {31'd0, m_valid});
      chk("data", o_mem_data, m_data);
      chk("busy", {31'd0, o_busy}, {31'd0, m_busy});
    end
  end

  task automatic request(input logic [7:0] blk);
    i_mem_req_addr  = blk;
    i_mem_req_valid = 1'b1;
    @(negedge clk);
    i_mem_req_valid = 1'b0;
    i_mem_req_addr  = 8'($urandom);
  endtask

  task automatic wait_word(input int k);
    int n;
    n = 0;
    while (!(m_send && m_word == k) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_word", {31'd0, (m_send && m_word == k)}, 32'd1);
  endtask

  task automatic run_stream(input logic [7:0] blk, output int words);
    int n;
    words = 0;
    n = 0;
    request(blk);
    while (o_busy && n < 80) begin
      if (o_mem_data_valid) words++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int lat, w;
    arst_n = 1'b0; i_halt = 1'b0; i_mem_req_addr = 8'd0; i_mem_req_valid = 1'b0;
    i_mem_ready = 1'b1; i_wr_en = 1'b0; i_wr_addr = 12'd0; i_wr_data = 32'd0;
    repeat (2) @(negedge clk);
    check_en = 1;
    chk("rst_valid", {31'd0, o_mem_data_valid}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_data", o_mem_data, 32'd0);
    arst_n = 1'b1;

    // Preload every word, with the block-3 words fixed, plus dropped out-of-range writes.
    for (int a = 0; a < WORD_DEPTH + 4; a++) begin
      i_wr_en   = 1'b1;
      i_wr_addr = 12'(a);
      i_wr_data = (a >= 30 && a < 40) ? 32'h40 + 32'(a - 30) : $urandom;
      @(negedge clk);
    end
    i_wr_en = 1'b0;

    // Block 3, ready high: first word LATENCY cycles after accept.
    request(8'd3);
    lat = 0;
    while (!o_mem_data_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("lat_035", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("w035", o_mem_data, 32'h40 + 32'(i));
      @(negedge clk);
    end
    chk("end_035", {31'd0, o_mem_data_valid}, 32'd0);

    // Ready held low, then raised; dropping it during SEND must not pause.
    i_mem_ready = 1'b0;
    request(8'd0);
    repeat (7) @(negedge clk);
    chk("hold_036", {31'd0, o_mem_data_valid}, 32'd0);
    i_mem_ready = 1'b1;
    @(negedge clk);
    i_mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("c036", {31'd0, o_mem_data_valid}, 32'd1);
      @(negedge clk);
    end
    chk("end_036", {31'd0, o_mem_data_valid}, 32'd0);
    i_mem_ready = 1'b1;

    // Request during a stream is ignored.
    request(8'd5);
    wait_word(5);
    request(8'd9);
    w = 0;
    while (o_busy && w < 40) begin @(negedge clk); w++; end
    chk("idle_037", {31'd0, o_busy}, 32'd0);
    run_stream(8'd6, w);
    chk("cnt_037", 32'(w), 32'd10);

    // Halt for 3 cycles on word 4.
    request(8'd7);
    wait_word(4);
    i_halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_038", o_mem_data, ref_mem[74]);
    end
    i_halt = 1'b0;
    wait_word(9);
    @(negedge clk);

    // Reset mid-stream, then the top block.
    request(8'd8);
    wait_word(6);
    arst_n = 1'b0;
    @(negedge clk);
    chk("rst_v039", {31'd0, o_mem_data_valid}, 32'd0);
    chk("rst_b039", {31'd0, o_busy}, 32'd0);
    arst_n = 1'b1;
    run_stream(8'd255, w);
    chk("cnt_039", 32'(w), 32'd10);

    // Back-to-back blocks 1 then 2.
    run_stream(8'd1, w);
    chk("cnt_040a", 32'(w), 32'd10);
    run_stream(8'd2, w);
    chk("cnt_040b", 32'(w), 32'd10);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      arst_n          = ($urandom_range(0, 199) != 0);
      i_halt          = ($urandom_range(0, 5) == 0);
      i_mem_ready     = ($urandom_range(0, 3) != 0);
      i_mem_req_valid = ($urandom_range(0, 5) == 0);
      i_mem_req_addr  = 8'($urandom);
      i_wr_en         = ($urandom_range(0, 2) == 0);
      i_wr_addr       = 12'($urandom_range(0, 4095));
      i_wr_data       = $urandom;
      @(negedge clk);
    end
    arst_n = 1'b1; i_halt = 1'b0; i_mem_ready = 1'b1; i_mem_req_valid = 1'b0; i_wr_en = 1'b0;
    w = 0;
    while (o_busy && w < 60) begin @(negedge clk); w++; end
    chk("final_idle", {31'd0, o_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
